data_mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory (18-bit word address, word/byte operations) between the CPU load/store path and a debug/loader port.
- Sequences each access through a fixed-latency memory cycle and returns read data with a one-cycle acknowledge.
- Drives a stall indication so the CPU can hold its PC while its access is pending.
- Sits between the datapath's memory stage and the data memory block.

---
 rtl/data_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU
// load/store path and a debug/loader port, with a fixed-latency access cycle.
module data_mem_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_byte,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_dbg;
    logic              r_owner_dbg;
    logic              r_we;
    logic              r_byte;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic [CNT_W-1:0]  r_count;

    logic              w_grant_any;
    logic              w_grant_dbg;
    logic              w_cpu_ack;
    logic              w_dbg_ack;

    // On a tie the port that did not win last time gets the memory.
    assign w_grant_any = cpu_req | dbg_req;
    assign w_grant_dbg = dbg_req & (~cpu_req | ~r_last_dbg);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_any) w_state_nxt = S_ACCESS;
            S_ACCESS: if (r_count == '0) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last_dbg  <= 1'b1;
            r_owner_dbg <= 1'b0;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner_dbg <= w_grant_dbg;
                        r_last_dbg  <= w_grant_dbg;
                        r_we        <= w_grant_dbg ? dbg_we    : cpu_we;
                        r_byte      <= w_grant_dbg ? dbg_byte  : cpu_byte;
                        r_addr      <= w_grant_dbg ? dbg_addr  : cpu_addr;
                        r_wdata     <= w_grant_dbg ? dbg_wdata : cpu_wdata;
                        r_count     <= CNT_W'(LATENCY - 1);
                    end
                end
                S_ACCESS: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CNT_W'(1);
                    end else if (!r_we) begin
                        if (r_owner_dbg) r_dbg_rdata <= mem_rdata;
                        else             r_cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_cpu_ack = (r_state == S_DONE) & ~r_owner_dbg;
    assign w_dbg_ack = (r_state == S_DONE) &  r_owner_dbg;

    assign cpu_ack   = w_cpu_ack;
    assign dbg_ack   = w_dbg_ack;
    assign cpu_stall = cpu_req & ~w_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign mem_read  = (r_state == S_ACCESS) & ~r_we;
    assign mem_write = (r_state == S_ACCESS) &  r_we;
    assign mem_byte  = r_byte;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;
    localparam int LAT1   = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic              cpu_req = 0, cpu_we = 0, cpu_byte = 0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req = 0, dbg_we = 0, dbg_byte = 0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
    logic              mem_read, mem_write, mem_byte, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    // second instance, LATENCY=1
    logic              c1_req = 0;
    logic [ADDR_W-1:0] c1_addr = '0;
    logic [DATA_W-1:0] c1_rdata, d1_rdata, m1_wdata, m1_rdata;
    logic              c1_ack, c1_stall, d1_ack, m1_read, m1_write, m1_byte, busy1;
    logic [ADDR_W-1:0] m1_addr;
    logic              tie0 = 1'b0;
    logic [ADDR_W-1:0] tie_a = '0;
    logic [DATA_W-1:0] tie_d = '0;
    assign m1_rdata = 32'h0BAD_F00D;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT)) u0 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_byte(dbg_byte), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT1)) u1 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(c1_req), .cpu_we(tie0), .cpu_byte(tie0), .cpu_addr(c1_addr),
        .cpu_wdata(tie_d), .cpu_rdata(c1_rdata), .cpu_ack(c1_ack), .cpu_stall(c1_stall),
        .dbg_req(tie0), .dbg_we(tie0), .dbg_byte(tie0), .dbg_addr(tie_a),
        .dbg_wdata(tie_d), .dbg_rdata(d1_rdata), .dbg_ack(d1_ack),
        .mem_read(m1_read), .mem_write(m1_write), .mem_byte(m1_byte), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .busy(busy1)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | i);
    endfunction

    // memory device seen by u0 (indexed by the low address byte)
    logic [31:0] dev_mem [0:255];
    bit          dev_ready = 0;
    always @(negedge clock) begin
        if (!dev_ready) begin
            for (int unsigned i = 0; i < 256; i++) dev_mem[i] = init_word(i);
            dev_ready = 1;
        end else if (mem_write) begin
            dev_mem[mem_addr[7:0]] = mem_wdata;
        end
    end
    assign mem_rdata = dev_mem[mem_addr[7:0]];

    // expected memory contents, updated when a write is granted
    logic [31:0] ref_mem [0:255];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        cpu_req = 0; dbg_req = 0; c1_req = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    task automatic run_xfer(input bit dbg, input bit we, input bit byt,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            output int lat, output int strobes, output bit addr_ok,
                            output bit other_ack, output bit stall_ok);
        bit own, oth;
        if (!dbg) begin
            cpu_req = 1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1; dbg_we = we; dbg_byte = byt; dbg_addr = addr; dbg_wdata = wdata;
        end
        lat = 0; strobes = 0; addr_ok = 1; other_ack = 0; stall_ok = 1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (mem_read || mem_write) begin
                strobes++;
                if (mem_addr !== addr || mem_byte !== byt || mem_write !== we || mem_wdata !== wdata)
                    addr_ok = 0;
            end
            own = dbg ? dbg_ack : cpu_ack;
            oth = dbg ? cpu_ack : dbg_ack;
            if (oth) other_ack = 1;
            if (!dbg && (cpu_stall !== !own)) stall_ok = 0;
            if (own) begin
                lat = n;
                break;
            end
        end
        cpu_req = 0; dbg_req = 0;
        if (we) ref_mem[addr[7:0]] = wdata;
    endtask

    typedef struct {
        bit              dbg;
        bit              we;
        bit              byt;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, strobes, nacks, idle_cnt, stall_n;
        bit addr_ok, other_ack, stall_ok;
        logic [31:0] exp_crd, exp_drd;
        int ack_port [4];
        int ack_cyc  [4];

        for (int unsigned i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        vecs[0] = '{0, 0, 0, 18'h00010, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1, 1, 1, 18'h3FFFF, 32'h0000_00A5, 32'h0};
        vecs[2] = '{1, 0, 0, 18'h3FFFF, 32'h0,        32'h0000_00A5};
        vecs[3] = '{0, 1, 0, 18'h00020, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[4] = '{0, 0, 0, 18'h00020, 32'h0,        32'h1234_5678};
        vecs[5] = '{1, 0, 0, 18'h00010, 32'h0,        32'hDEAD_BEEF};

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dbg_ack", dbg_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_byte", mem_byte, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        reset_n = 1;

        // ---- directed vector table ----
        exp_crd = '0; exp_drd = '0;
        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].dbg, vecs[v].we, vecs[v].byt, vecs[v].addr, vecs[v].wdata,
                     lat, strobes, addr_ok, other_ack, stall_ok);
            if (vecs[v].dbg) exp_drd = vecs[v].exp_rdata;
            else             exp_crd = vecs[v].exp_rdata;
            check($sformatf("vec%0d_latency", v), lat, LAT + 1);
            check($sformatf("vec%0d_strobes", v), strobes, LAT);
            check($sformatf("vec%0d_mem_fields", v), addr_ok, 1);
            check($sformatf("vec%0d_other_ack", v), other_ack, 0);
            check($sformatf("vec%0d_cpu_stall", v), stall_ok, 1);
            check($sformatf("vec%0d_cpu_rdata", v), cpu_rdata, exp_crd);
            check($sformatf("vec%0d_dbg_rdata", v), dbg_rdata, exp_drd);
            @(negedge clock);
        end

        // ---- contention after reset: both held, round-robin ----
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 18'h00020;
        nacks = 0; idle_cnt = 0;
        for (int n = 1; n <= 40 && nacks < 4; n++) begin
            @(negedge clock);
            if (nacks > 0 && !busy) idle_cnt++;
            if (cpu_ack || dbg_ack) begin
                ack_port[nacks] = (cpu_ack && dbg_ack) ? 2 : (dbg_ack ? 1 : 0);
                ack_cyc[nacks]  = n;
                nacks++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("rr_ack_count", nacks, 4);
        check("rr_first_latency", ack_cyc[0], LAT + 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_order%0d", i), ack_port[i], i % 2);
            if (i > 0) check($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], LAT + 2);
        end
        check("rr_idle_cycles", idle_cnt, 3);
        check("rr_cpu_rdata", cpu_rdata, ref_mem[8'h10]);
        check("rr_dbg_rdata", dbg_rdata, ref_mem[8'h20]);
        @(negedge clock);

        // ---- input change and req drop after grant ----
        cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00020;
        addr_ok = 1; nacks = 0; strobes = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (mem_read) begin
                strobes++;
                if (mem_addr !== 18'h00020) addr_ok = 0;
            end
            if (cpu_ack) nacks++;
            if (n == 1) begin
                cpu_addr = 18'h00030; cpu_we = 1; cpu_req = 0;
            end
        end
        check("chg_mem_addr", addr_ok, 1);
        check("chg_strobes", strobes, LAT);
        check("chg_ack_count", nacks, 1);
        check("chg_cpu_rdata", cpu_rdata, ref_mem[8'h20]);
        cpu_we = 0;

        // ---- reset in the second ACCESS cycle ----
        cpu_req = 1; cpu_addr = 18'h00010;
        repeat (2) @(negedge clock);
        check("abort_pre_read", mem_read, 1);
        #2;
        reset_n = 0; cpu_req = 0;
        #1;
        check("abort_mem_read", mem_read, 0);
        check("abort_busy", busy, 0);
        check("abort_cpu_ack", cpu_ack, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        check("abort_mem_addr", mem_addr, 0);
        @(negedge clock);
        reset_n = 1;
        nacks = 0;
        repeat (6) begin
            @(negedge clock);
            if (cpu_ack || dbg_ack || busy) nacks++;
        end
        check("abort_no_ack", nacks, 0);
        cpu_req = 1; cpu_addr = 18'h00011;
        dbg_req = 1; dbg_addr = 18'h00012;
        lat = 0; addr_ok = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (mem_read && lat == 0) begin
                lat = n;
                addr_ok = (mem_addr === 18'h00011);
            end
            if (cpu_ack || dbg_ack) begin
                other_ack = dbg_ack;
                break;
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("abort_tie_cpu_addr", addr_ok, 1);
        check("abort_tie_dbg_ack", other_ack, 0);
        @(negedge clock);

        // ---- randomized traffic vs transaction-level model ----
        begin
            bit              p_req [2], p_we [2], p_byte [2], pend [2], granted [2];
            logic [ADDR_W-1:0] p_addr [2];
            logic [DATA_W-1:0] p_wdata [2];
            bit gvalid, g_owner, g_we, g_byte, last, acc, done, stop_new, ack_p, w;
            logic [ADDR_W-1:0] g_addr;
            logic [DATA_W-1:0] g_wdata, g_rval;
            int g, free_at, npend;

            do_reset();
            for (int p = 0; p < 2; p++) begin
                p_req[p] = 0; p_we[p] = 0; p_byte[p] = 0; pend[p] = 0; granted[p] = 0;
                p_addr[p] = '0; p_wdata[p] = '0;
            end
            gvalid = 0; g = 0; free_at = 0; last = 1; g_owner = 0; g_we = 0; g_byte = 0;
            g_addr = '0; g_wdata = '0; g_rval = '0; exp_crd = '0; exp_drd = '0;

            for (int c = 0; c < 600; c++) begin
                if (c > 0) @(negedge clock);
                stop_new = (c >= 570);
                acc  = gvalid && (c >= g + 1) && (c <= g + LAT);
                done = gvalid && (c == g + LAT + 1);
                if (done && !g_we) begin
                    if (g_owner) exp_drd = g_rval;
                    else         exp_crd = g_rval;
                end
                check("rnd_mem_read", mem_read, acc & ~g_we);
                check("rnd_mem_write", mem_write, acc & g_we);
                check("rnd_busy", busy, acc | done);
                check("rnd_cpu_ack", cpu_ack, done & ~g_owner);
                check("rnd_dbg_ack", dbg_ack, done & g_owner);
                check("rnd_cpu_rdata", cpu_rdata, exp_crd);
                check("rnd_dbg_rdata", dbg_rdata, exp_drd);
                check("rnd_mem_addr", mem_addr, g_addr);
                check("rnd_mem_wdata", mem_wdata, g_wdata);
                check("rnd_mem_byte", mem_byte, g_byte);
                check("rnd_cpu_stall", cpu_stall, cpu_req & ~(done & ~g_owner));

                for (int p = 0; p < 2; p++) begin
                    ack_p = done && (g_owner == p[0]);
                    if (ack_p || (!pend[p] && !stop_new && $urandom_range(2) == 0)) begin
                        if (ack_p) begin
                            pend[p] = 0; granted[p] = 0; p_req[p] = 0;
                        end
                        if (!stop_new && (!ack_p || $urandom_range(1) == 1)) begin
                            pend[p] = 1; p_req[p] = 1;
                            p_we[p] = $urandom_range(1) == 1; p_byte[p] = $urandom_range(1) == 1;
                            p_addr[p] = ADDR_W'($urandom); p_wdata[p] = $urandom;
                        end
                    end else if (pend[p] && granted[p]) begin
                        if ($urandom_range(3) == 0) begin
                            p_we[p] = ~p_we[p]; p_addr[p] = ADDR_W'($urandom); p_wdata[p] = $urandom;
                        end
                        if ($urandom_range(3) == 0) p_req[p] = 0;
                    end
                end
                cpu_req = p_req[0]; cpu_we = p_we[0]; cpu_byte = p_byte[0];
                cpu_addr = p_addr[0]; cpu_wdata = p_wdata[0];
                dbg_req = p_req[1]; dbg_we = p_we[1]; dbg_byte = p_byte[1];
                dbg_addr = p_addr[1]; dbg_wdata = p_wdata[1];

                if (c >= free_at && (p_req[0] || p_req[1])) begin
                    w = (p_req[0] && p_req[1]) ? ~last : p_req[1];
                    gvalid = 1; g = c; free_at = c + LAT + 2;
                    g_owner = w; last = w; granted[w] = 1;
                    g_we = p_we[w]; g_byte = p_byte[w]; g_addr = p_addr[w]; g_wdata = p_wdata[w];
                    if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
                    else      g_rval = ref_mem[g_addr[7:0]];
                end
            end
            npend = int'(pend[0]) + int'(pend[1]);
            check("rnd_all_completed", npend, 0);
            cpu_req = 0; dbg_req = 0;
            @(negedge clock);
        end

        // ---- LATENCY=1 instance ----
        c1_req = 1; c1_addr = 18'h00055;
        #1;
        stall_n = c1_stall ? 1 : 0;
        lat = 0; strobes = 0; addr_ok = 1; stall_ok = 1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (m1_read) begin
                strobes++;
                if (m1_addr !== 18'h00055) addr_ok = 0;
            end
            if (c1_ack) begin
                if (c1_stall) stall_ok = 0;
                lat = n;
                break;
            end
            if (c1_stall) stall_n++;
        end
        c1_req = 0;
        check("lat1_latency", lat, LAT1 + 1);
        check("lat1_strobes", strobes, LAT1);
        check("lat1_mem_addr", addr_ok, 1);
        check("lat1_stall_cycles", stall_n, LAT1 + 1);
        check("lat1_stall_at_ack", stall_ok, 1);
        check("lat1_cpu_rdata", c1_rdata, 32'h0BAD_F00D);
        check("lat1_dbg_ack", d1_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
